memory_dump_controller: RTL and testbench
=========================================

MEMORY_DUMP_CONTROLLER -- requirements
Module: memory_dump_controller

Interface
REQ-001 The block SHALL have parameter LAST_ADDR, default 1023, giving the final word address dumped (0..1023).
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; the memory block's debugClk is tied to clk at top level.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: dump request, sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous cancel.
REQ-006 The block SHALL have port ReadData, input, 32 bits: memory-access block read data, valid one cycle after the address is driven.
REQ-007 The block SHALL have port txReady, input, 1 bit: byte sink ready.
REQ-008 The block SHALL have port debugMode, output, 1 bit: forces the memory-access block into debug addressing.
REQ-009 The block SHALL have port DebugAddress, output, 32 bits: word address, bits 31:10 always zero.
REQ-010 The block SHALL have port txData, output, 8 bits: byte to sink.
REQ-011 The block SHALL have port txValid, output, 1 bit: txData valid.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on dump completion.

Function
REQ-014 The FSM SHALL use states IDLE, ADDR, CAPTURE, SEND, NEXT, TRAILER.
REQ-015 IDLE with start=1 SHALL go to ADDR, clear the word counter to 0 and assert debugMode.
REQ-016 ADDR SHALL drive DebugAddress = counter for one cycle, then go to CAPTURE.
REQ-017 CAPTURE SHALL latch ReadData into a 32-bit shift register, clear the byte index and go to SEND.
REQ-018 The first txValid SHALL therefore assert exactly 3 rising edges after the edge that samples start.
REQ-019 SEND SHALL present bytes MSB first: ReadData[31:24], [23:16], [15:8], [7:0].
REQ-020 A byte SHALL transfer on a rising edge where txValid=1 and txReady=1.
REQ-021 txData SHALL be held stable while txValid=1 and txReady=0.
REQ-022 After the 4th transfer, SEND SHALL go to NEXT.
REQ-023 NEXT SHALL increment the counter and go to ADDR if the old counter < LAST_ADDR; otherwise it SHALL go to TRAILER (with the checksum feature) or to IDLE.
REQ-024 The counter SHALL be 10 bits wide and SHALL never wrap past LAST_ADDR.
REQ-025 Back-to-back transfers SHALL be allowed: with txReady held high, one byte SHALL transfer per cycle within a word.
REQ-026 Each word SHALL occupy 4 + 3 = 7 cycles with txReady high.
REQ-027 done SHALL pulse for the single cycle in which the FSM re-enters IDLE after a completed dump.
REQ-028 debugMode SHALL deassert in that same cycle.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 start and abort asserted together in IDLE SHALL be ignored.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next edge and drop txValid, debugMode and busy; done SHALL NOT pulse; no partial byte SHALL be counted as transferred.

Reset
REQ-032 rst_n low SHALL immediately force IDLE with txValid=0, txData=0, debugMode=0, DebugAddress=0, busy=0, done=0, counter=0, checksum=0.
REQ-033 Reset mid-dump SHALL abandon the dump without a done pulse.

Configuration
REQ-034 With macro DUMP_CHECKSUM_EN defined, the block SHALL XOR every transferred data byte into an 8-bit checksum (cleared on start).
REQ-035 With DUMP_CHECKSUM_EN defined, TRAILER SHALL send that checksum as one extra byte under the same handshake, then go to IDLE and pulse done.
REQ-036 Without DUMP_CHECKSUM_EN, the TRAILER state and checksum register SHALL be absent and NEXT SHALL go straight to IDLE.

Verification
REQ-037 LAST_ADDR=1, mem[0]=0x11223344, mem[1]=0xA0B0C0D0, txReady=1: pulse start -> bytes 11,22,33,44,A0,B0,C0,D0, first txValid at edge 3; done pulses once; debugMode low afterwards.
REQ-038 Same setup with DUMP_CHECKSUM_EN defined -> 9th byte 0x44 (XOR of all 8 bytes); done after the 9th transfer.
REQ-039 txReady low for 5 cycles while byte 0x22 is pending -> txData stays 0x22, txValid stays 1, no byte skipped or duplicated.
REQ-040 abort asserted during SEND of word 0 -> next cycle busy=0, txValid=0, debugMode=0, no done; a new start restarts from address 0.
REQ-041 rst_n pulsed low during word 1 -> all outputs zero asynchronously; start pulsed during busy is ignored (byte count unchanged).
REQ-042 LAST_ADDR=1023 full dump with random txReady -> 4096 bytes matching memory contents; DebugAddress never exceeds 1023.

Source files
------------

// File: rtl/memory_dump_controller.sv
// Streams memory words 0..LAST_ADDR as MSB-first bytes over a valid/ready byte sink.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after the last word.
module memory_dump_controller #(
   parameter int LAST_ADDR = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] ReadData,
   input  logic        txReady,
   output logic        debugMode,
   output logic [31:0] DebugAddress,
   output logic [7:0]  txData,
   output logic        txValid,
   output logic        busy,
   output logic        done
);

   localparam logic [9:0] LAST_WORD = 10'(LAST_ADDR);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      CAPTURE,
      SEND,
      NEXT
`ifdef DUMP_CHECKSUM_EN
      , TRAILER
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  counter_q, counter_d;
   logic [31:0] shift_q, shift_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic        done_q, done_d;
   logic        transfer;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]  checksum_q, checksum_d;
`endif

   // Abort wins over a same-cycle handshake, so an aborted byte never counts.
   assign transfer = txValid && txReady && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         counter_q  <= '0;
         shift_q    <= '0;
         byte_idx_q <= '0;
         done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         done_q     <= done_d;
`ifdef DUMP_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q != IDLE && abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start && !abort) state_d = ADDR;
            ADDR:    state_d = CAPTURE;
            CAPTURE: state_d = SEND;
            SEND:    if (transfer && byte_idx_q == 2'd3) state_d = NEXT;
            NEXT: begin
               if (counter_q < LAST_WORD) begin
                  state_d = ADDR;
               end else begin
`ifdef DUMP_CHECKSUM_EN
                  state_d = TRAILER;
`else
                  state_d = IDLE;
`endif
               end
            end
`ifdef DUMP_CHECKSUM_EN
            TRAILER: if (transfer) state_d = IDLE;
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      counter_d  = counter_q;
      shift_d    = shift_q;
      byte_idx_d = byte_idx_q;
      done_d     = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      checksum_d = checksum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               counter_d = '0;
`ifdef DUMP_CHECKSUM_EN
               checksum_d = '0;
`endif
            end
         end
         CAPTURE: begin
            shift_d    = ReadData;
            byte_idx_d = '0;
         end
         SEND: begin
            if (transfer) begin
               shift_d    = {shift_q[23:0], 8'h00};
               byte_idx_d = byte_idx_q + 2'd1;
`ifdef DUMP_CHECKSUM_EN
               checksum_d = checksum_q ^ shift_q[31:24];
`endif
            end
         end
         NEXT: begin
            if (!abort) begin
               if (counter_q < LAST_WORD) begin
                  counter_d = counter_q + 10'd1;
               end else begin
`ifndef DUMP_CHECKSUM_EN
                  done_d = 1'b1;
`endif
               end
            end
         end
`ifdef DUMP_CHECKSUM_EN
         TRAILER: if (transfer) done_d = 1'b1;
`endif
         default: ;
      endcase
   end

   always_comb begin
      busy         = (state_q != IDLE);
      debugMode    = busy;
      done         = done_q;
      txValid      = 1'b0;
      txData       = 8'h00;
      DebugAddress = 32'h0;
      case (state_q)
         ADDR: DebugAddress = {22'd0, counter_q};
         SEND: begin
            txValid = 1'b1;
            txData  = shift_q[31:24];
         end
`ifdef DUMP_CHECKSUM_EN
         TRAILER: begin
            txValid = 1'b1;
            txData  = checksum_q;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_memory_dump_controller.sv
// Self-checking bench for memory_dump_controller: byte-stream reference model plus directed literals.
// Honours DUMP_CHECKSUM_EN the same way the design does.
`timescale 1ns/1ps
module tb_memory_dump_controller;

   localparam int LAST_ADDR = 1023;
   localparam int N_WORDS   = LAST_ADDR + 1;
`ifdef DUMP_CHECKSUM_EN
   localparam bit CSUM        = 1'b1;
   localparam int TOTAL_BYTES = 4 * N_WORDS + 1;
   localparam int DUMP_EDGES  = 7 * N_WORDS + 1;
`else
   localparam bit CSUM        = 1'b0;
   localparam int TOTAL_BYTES = 4 * N_WORDS;
   localparam int DUMP_EDGES  = 7 * N_WORDS;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        txReady = 1'b0;
   logic [31:0] ReadData;
   logic        debugMode;
   logic [31:0] DebugAddress;
   logic [7:0]  txData;
   logic        txValid;
   logic        busy;
   logic        done;

   logic [31:0] mem [0:LAST_ADDR];

   int errors = 0;
   int checks = 0;
   int edge_cnt = 0;

   // Reference model state: expected byte stream and where the dump currently is.
   logic [7:0] m_bytes[$];
   bit         m_active = 1'b0;
   bit         m_done = 1'b0;
   bit         m_tail = 1'b0;
   int         m_gap = 0;
   int         m_pos = 0;

   // Observations used by the directed literal checks.
   logic [7:0] got_q[$];
   int         start_edge = 0;
   int         first_valid_edge = 0;
   int         done_edge = 0;
   int         done_count = 0;
   bit         seen_valid = 1'b0;

   always #5 clk = ~clk;

   memory_dump_controller #(.LAST_ADDR(LAST_ADDR)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .ReadData(ReadData),
      .txReady(txReady),
      .debugMode(debugMode),
      .DebugAddress(DebugAddress),
      .txData(txData),
      .txValid(txValid),
      .busy(busy),
      .done(done)
   );

   // Memory-access block: read data appears one cycle after the address.
   always @(posedge clk) ReadData <= mem[DebugAddress[9:0]];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic r);
      @(posedge clk);
      #2;
      start   = s;
      abort   = a;
      txReady = r;
   endtask

   task automatic buildBytes();
      logic [7:0] csum;
      logic [31:0] w;
      csum = 8'h00;
      m_bytes.delete();
      for (int i = 0; i < N_WORDS; i++) begin
         w = mem[i];
         for (int b = 3; b >= 0; b--) begin
            m_bytes.push_back(w[8*b +: 8]);
            csum = csum ^ w[8*b +: 8];
         end
      end
      if (CSUM) m_bytes.push_back(csum);
   endtask

   task automatic checkZeros(input string tag);
      checkOutput({tag, "_txValid"}, 32'(txValid), 32'd0);
      checkOutput({tag, "_txData"}, 32'(txData), 32'd0);
      checkOutput({tag, "_debugMode"}, 32'(debugMode), 32'd0);
      checkOutput({tag, "_DebugAddress"}, DebugAddress, 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Compare process: on every falling edge check the DUT against the model, then advance the model.
   always @(negedge clk) begin : compare_proc
      bit exp_valid;
      if (!rst_n) begin
         checkZeros("reset");
         m_active = 1'b0;
         m_done   = 1'b0;
         m_tail   = 1'b0;
      end else begin
         exp_valid = m_active && !m_tail && (m_gap == 0) && (m_pos < m_bytes.size());
         checkOutput("busy", 32'(busy), 32'(m_active));
         checkOutput("debugMode", 32'(debugMode), 32'(m_active));
         checkOutput("done", 32'(done), 32'(m_done));
         checkOutput("txValid", 32'(txValid), 32'(exp_valid));
         checkOutput("addr_high_zero", 32'(DebugAddress[31:10]), 32'd0);
         if (exp_valid) checkOutput("txData", 32'(txData), 32'(m_bytes[m_pos]));
         if (m_active && m_gap == 2) checkOutput("DebugAddress", DebugAddress, 32'(m_pos / 4));

         if (txValid && !seen_valid) begin
            seen_valid = 1'b1;
            first_valid_edge = edge_cnt;
         end
         if (done) begin
            done_count++;
            done_edge = edge_cnt;
         end
         if (txValid && txReady && !abort) got_q.push_back(txData);

         m_done = 1'b0;
         if (!m_active) begin
            if (start && !abort) begin
               m_active   = 1'b1;
               m_gap      = 2;
               m_pos      = 0;
               m_tail     = 1'b0;
               buildBytes();
               start_edge = edge_cnt + 1;
               seen_valid = 1'b0;
            end
         end else if (abort) begin
            m_active = 1'b0;
            m_tail   = 1'b0;
         end else if (exp_valid && txReady) begin
            m_pos++;
            if (m_pos == m_bytes.size()) begin
               if (CSUM) begin
                  m_active = 1'b0;
                  m_done   = 1'b1;
               end else begin
                  m_tail = 1'b1;
               end
            end else if (m_pos % 4 == 0) begin
               m_gap = (CSUM && m_pos == m_bytes.size() - 1) ? 1 : 3;
            end
         end else if (m_tail) begin
            m_active = 1'b0;
            m_tail   = 1'b0;
            m_done   = 1'b1;
         end else if (m_gap > 0) begin
            m_gap--;
         end
      end
   end

   initial begin
      logic [7:0] lit [8];
      int n;
      int dc;
      lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB0, 8'hC0, 8'hD0};

      for (int i = 0; i < N_WORDS; i++) mem[i] = 32'h0;
      mem[0] = 32'h11223344;
      mem[1] = 32'hA0B0C0D0;

      #1 rst_n = 1'b0;
      #1 checkZeros("por");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(0, 0, 1);

      // Directed full dump with the sink always ready.
      $display("[TB] directed full dump, txReady high");
      got_q.delete();
      done_count = 0;
      applyStimulus(1, 0, 1);
      n = 0;
      applyStimulus(0, 0, 1);
      while (done_count == 0 && n < DUMP_EDGES + 50) begin
         applyStimulus(0, 0, 1);
         n++;
      end
      checkOutput("dump1_done_seen", 32'(done_count), 32'd1);
      checkOutput("dump1_byte_count", 32'(got_q.size()), 32'(TOTAL_BYTES));
      for (int i = 0; i < 8; i++)
         if (got_q.size() > i) checkOutput($sformatf("dump1_byte%0d", i), 32'(got_q[i]), 32'(lit[i]));
      checkOutput("first_valid_edge", 32'(first_valid_edge - start_edge + 1), 32'd3);
      checkOutput("dump1_done_edge", 32'(done_edge - start_edge), 32'(DUMP_EDGES));
`ifdef DUMP_CHECKSUM_EN
      if (got_q.size() > 0) checkOutput("checksum_byte", 32'(got_q[got_q.size()-1]), 32'h44);
`endif
      applyStimulus(0, 0, 1);
      checkOutput("post_done_debugMode", 32'(debugMode), 32'd0);
      checkOutput("post_done_busy", 32'(busy), 32'd0);
      checkOutput("done_single_pulse", 32'(done_count), 32'd1);

      // Stall on byte 0x22, then abort mid-word.
      $display("[TB] stall and abort");
      got_q.delete();
      applyStimulus(1, 0, 1);
      n = 0;
      do begin
         applyStimulus(0, 0, 1);
         n++;
      end while (!(txValid && txData == 8'h22) && n < 20);
      checkOutput("reach_0x22", 32'(txData), 32'h22);
      txReady = 1'b0;
      checkOutput("stall_valid_0", 32'(txValid), 32'd1);
      for (int i = 1; i < 5; i++) begin
         applyStimulus(0, 0, 0);
         checkOutput($sformatf("stall_data_%0d", i), 32'(txData), 32'h22);
         checkOutput($sformatf("stall_valid_%0d", i), 32'(txValid), 32'd1);
      end
      checkOutput("stall_no_skip", 32'(got_q.size()), 32'd1);
      n = 0;
      while (got_q.size() < 3 && n < 20) begin
         applyStimulus(0, 0, 1);
         n++;
      end
      checkOutput("after_stall_b1", 32'(got_q[1]), 32'h22);
      checkOutput("after_stall_b2", 32'(got_q[2]), 32'h33);
      checkOutput("pre_abort_valid", 32'(txValid), 32'd1);
      dc = done_count;
      abort = 1'b1;
      applyStimulus(0, 0, 1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_txValid", 32'(txValid), 32'd0);
      checkOutput("abort_debugMode", 32'(debugMode), 32'd0);
      checkOutput("abort_no_partial", 32'(got_q.size()), 32'd3);
      applyStimulus(0, 0, 1);
      checkOutput("abort_no_done", 32'(done_count), 32'(dc));

      // Restart from address 0, then reset in the middle of word 1.
      $display("[TB] restart and mid-dump reset");
      got_q.delete();
      applyStimulus(1, 0, 1);
      n = 0;
      while (got_q.size() < 6 && n < 30) begin
         applyStimulus(0, 0, 1);
         n++;
      end
      checkOutput("restart_b0", 32'(got_q[0]), 32'h11);
      checkOutput("restart_b4", 32'(got_q[4]), 32'hA0);
      applyStimulus(1, 0, 1);
      applyStimulus(0, 0, 1);
      checkOutput("start_ignored_busy", 32'(busy), 32'd1);
      dc = done_count;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkZeros("async_reset");
      applyStimulus(0, 0, 1);
      rst_n = 1'b1;
      repeat (3) applyStimulus(0, 0, 1);
      checkOutput("reset_no_done", 32'(done_count), 32'(dc));
      checkOutput("reset_idle_busy", 32'(busy), 32'd0);

      // Random memory, random sink readiness, stray start pulses while busy.
      $display("[TB] randomized full dump");
      for (int i = 0; i < N_WORDS; i++) mem[i] = $urandom;
      got_q.delete();
      done_count = 0;
      applyStimulus(1, 0, ($urandom_range(0, 99) < 60));
      n = 0;
      while (done_count == 0 && n < 40000) begin
         applyStimulus(($urandom_range(0, 49) == 0), 1'b0, ($urandom_range(0, 99) < 60));
         n++;
      end
      checkOutput("dump2_done_seen", 32'(done_count), 32'd1);
      checkOutput("dump2_byte_count", 32'(got_q.size()), 32'(TOTAL_BYTES));

      // Random start/abort/reset traffic.
      $display("[TB] random control traffic");
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            @(posedge clk);
            #2 rst_n = 1'b0;
            applyStimulus(1'b0, 1'b0, 1'b1);
            rst_n = 1'b1;
         end else begin
            applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 1) == 1));
         end
      end

      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
